// File: rtl/uart_axis_tx.sv
// UART transmitter fed by an AXI4-Stream slave port: one word per handshake,
// framed as start, LSB-first data, optional parity and stop bit(s) on tx.
module uart_axis_tx #(
  parameter int    CLK_FREQ  = 50_000_000,
  parameter int    BAUD      = 115200,
  parameter int    DATA_BITS = 8,
  parameter string PARITY    = "even",
  parameter int    STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV) + 1;
  localparam int BW       = $clog2(DATA_BITS) + 1;
  localparam bit HAS_PAR  = (PARITY != "none");
  localparam bit ODD_PAR  = (PARITY == "odd");

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PAR    = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]           state_reg, state_next;
  logic [CW-1:0]        baud_reg, baud_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 tx_reg, tx_next;
  logic                 bit_end;

  assign s_axis_tready = (state_reg == IDLE) && !rst;
  assign busy          = (state_reg != IDLE);
  assign tx            = tx_reg;
  assign bit_end       = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;

    // Every non-idle state times its bit with the same free-running divider.
    if (state_reg != IDLE) begin
      baud_next = bit_end ? '0 : baud_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        tx_next   = 1'b1;
        if (s_axis_tvalid && s_axis_tready) begin
          shift_next = s_axis_tdata;
          par_next   = ODD_PAR ? ~^s_axis_tdata : ^s_axis_tdata;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (HAS_PAR) begin
              state_next = PAR;
              tx_next    = par_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
            bit_next   = bit_reg + 1'b1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
          bit_next   = '0;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (bit_reg == STOP_LAST) begin
            state_next = IDLE;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        baud_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_axis_tx.sv
// Bench for uart_axis_tx: three parity/stop variants driven with random words,
// each frame compared bit-by-bit against a frame model built from the line format.
`timescale 1ns/1ps
module tb_uart_axis_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int DIV0   = CLK_HZ / 90_000;   // 11, exercises the integer divide
  localparam int DIV12  = CLK_HZ / 125_000;  // 8

  logic       clk;
  logic       rst;
  logic [7:0] tdata  [3];
  logic       tvalid [3];
  logic       tready [3];
  logic       tx     [3];
  logic       busy   [3];

  int checks;
  int passed;
  int cyc;

  logic       rx_en;
  logic [7:0] rx_words [$];
  bit         rx_bad   [$];

  uart_axis_tx #(.CLK_FREQ(CLK_HZ), .BAUD(90_000), .DATA_BITS(8), .PARITY("even"), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]),
    .s_axis_tready(tready[0]), .tx(tx[0]), .busy(busy[0]));
  uart_axis_tx #(.CLK_FREQ(CLK_HZ), .BAUD(125_000), .DATA_BITS(8), .PARITY("odd"), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]),
    .s_axis_tready(tready[1]), .tx(tx[1]), .busy(busy[1]));
  uart_axis_tx #(.CLK_FREQ(CLK_HZ), .BAUD(125_000), .DATA_BITS(8), .PARITY("none"), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[2]), .s_axis_tvalid(tvalid[2]),
    .s_axis_tready(tready[2]), .tx(tx[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input int s);
    return (s == 0) ? DIV0 : DIV12;
  endfunction

  function automatic int stop_of(input int s);
    return (s == 2) ? 2 : 1;
  endfunction

  // 0: even parity, 1: odd parity, 2: no parity
  function automatic int frame_len(input int s);
    return (1 + 8 + ((s != 2) ? 1 : 0) + stop_of(s)) * div_of(s);
  endfunction

  // Behavioural receiver on u0: mid-bit sampling, even parity, one stop bit.
  always begin : rx_model
    logic [7:0] w;
    bit         bad;
    @(negedge clk);
    if (rx_en && tx[0] === 1'b0) begin
      bad = 1'b0;
      w   = '0;
      repeat (DIV0 / 2) @(negedge clk);
      if (tx[0] !== 1'b0) bad = 1'b1;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV0) @(negedge clk);
        w[i] = tx[0];
      end
      repeat (DIV0) @(negedge clk);
      if (tx[0] !== ^w) bad = 1'b1;
      repeat (DIV0) @(negedge clk);
      if (tx[0] !== 1'b1) bad = 1'b1;
      rx_words.push_back(w);
      rx_bad.push_back(bad);
    end
  end

  // Called at a negedge (or just after a posedge); returns just after the handshake edge.
  task automatic do_handshake(input int s, input logic [7:0] d, input bit keep,
                              input logic [7:0] nxt, output int hs_cyc);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    tdata[s]  = d;
    tvalid[s] = 1'b1;
    while (!done && n < 2000) begin
      if (tready[s] === 1'b1) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    #1;
    hs_cyc    = cyc;
    tvalid[s] = keep;
    tdata[s]  = keep ? nxt : 8'($urandom);
    checks++;
    if (!done) $display("FAIL handshake u%0d: tready never seen within %0d cycles, required within 2000", s, n);
    else passed++;
  endtask

  task automatic check_frame(input int s, input logic [7:0] d);
    logic q[$];
    int   bad;
    logic got_tx, got_busy, got_rdy;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (s == 0) q.push_back(^d);
    if (s == 1) q.push_back(~^d);
    for (int i = 0; i < stop_of(s); i++) q.push_back(1'b1);
    for (int b = 0; b < q.size(); b++) begin
      bad = 0;
      got_tx = q[b]; got_busy = 1'b1; got_rdy = 1'b0;
      repeat (div_of(s)) begin
        @(negedge clk);
        if (tx[s] !== q[b] || busy[s] !== 1'b1 || tready[s] !== 1'b0) begin
          bad++;
          got_tx = tx[s]; got_busy = busy[s]; got_rdy = tready[s];
        end
      end
      checks++;
      if (bad != 0)
        $display("FAIL frame_bit u%0d data=%02h bit%0d: tx=%b busy=%b tready=%b in %0d clocks, required tx=%b busy=1 tready=0",
                 s, d, b, got_tx, got_busy, got_rdy, bad, q[b]);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (tx[s] !== 1'b1 || busy[s] !== 1'b0 || tready[s] !== 1'b1)
      $display("FAIL frame_end u%0d data=%02h: tx=%b busy=%b tready=%b, required tx=1 busy=0 tready=1",
               s, d, tx[s], busy[s], tready[s]);
    else passed++;
    $display("frame u%0d data=%02h checked (%0d bits)", s, d, q.size());
  endtask

  task automatic send_check(input int s, input logic [7:0] d);
    int h;
    do_handshake(s, d, 1'b0, 8'h00, h);
    check_frame(s, d);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tvalid[s] = 1'b1;
      tdata[s]  = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (tx[s] !== 1'b1 || tready[s] !== 1'b0 || busy[s] !== 1'b0)
        $display("FAIL reset_hold u%0d: tx=%b tready=%b busy=%b, required tx=1 tready=0 busy=0",
                 s, tx[s], tready[s], busy[s]);
      else passed++;
      tvalid[s] = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (tready[s] !== 1'b1 || tx[s] !== 1'b1 || busy[s] !== 1'b0)
        $display("FAIL reset_release u%0d: tready=%b tx=%b busy=%b, required tready=1 tx=1 busy=0",
                 s, tready[s], tx[s], busy[s]);
      else passed++;
    end
    @(negedge clk);
  endtask

  task automatic test_even;
    send_check(0, 8'h55);
    send_check(0, 8'h07);
    repeat (4) send_check(0, 8'($urandom));
  endtask

  task automatic test_odd;
    send_check(1, 8'h07);
    repeat (3) send_check(1, 8'($urandom));
  endtask

  task automatic test_none_two_stop;
    send_check(2, 8'h07);
    repeat (3) send_check(2, 8'($urandom));
  endtask

  task automatic test_back_to_back(input int s, input logic [7:0] a, input logic [7:0] b);
    int h1, h2;
    do_handshake(s, a, 1'b1, b, h1);
    check_frame(s, a);
    do_handshake(s, b, 1'b0, 8'h00, h2);
    checks++;
    if (h2 - h1 !== frame_len(s) + 1)
      $display("FAIL b2b_period u%0d: handshake gap=%0d clocks, required %0d", s, h2 - h1, frame_len(s) + 1);
    else passed++;
    check_frame(s, b);
  endtask

  task automatic test_reset_midframe;
    int h;
    do_handshake(0, 8'hFF, 1'b0, 8'h00, h);
    repeat ((1 + 3) * DIV0 + DIV0 / 2) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b1)
      $display("FAIL midframe_pre: tx=%b busy=%b, required tx=1 busy=1 in data bit 3 of FF", tx[0], busy[0]);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || tready[0] !== 1'b0)
      $display("FAIL midframe_abort: tx=%b busy=%b tready=%b, required tx=1 busy=0 tready=0",
               tx[0], busy[0], tready[0]);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (tready[0] !== 1'b1 || tx[0] !== 1'b1)
      $display("FAIL midframe_release: tready=%b tx=%b, required tready=1 tx=1", tready[0], tx[0]);
    else passed++;
    @(negedge clk);
    send_check(0, 8'h12);
  endtask

  task automatic test_loopback;
    logic [7:0] sent [$];
    logic [7:0] w;
    int h;
    rx_words.delete();
    rx_bad.delete();
    rx_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom);
      sent.push_back(w);
      do_handshake(0, w, (i < 255), 8'($urandom), h);
    end
    repeat (frame_len(0) + 3 * DIV0) @(negedge clk);
    rx_en = 1'b0;
    checks++;
    if (rx_words.size() != sent.size())
      $display("FAIL loopback_count: received %0d words, required %0d", rx_words.size(), sent.size());
    else passed++;
    for (int i = 0; i < sent.size() && i < rx_words.size(); i++) begin
      checks++;
      if (rx_words[i] !== sent[i] || rx_bad[i])
        $display("FAIL loopback_word %0d: got %02h framing_err=%0d, required %02h framing_err=0",
                 i, rx_words[i], rx_bad[i], sent[i]);
      else begin
        passed++;
        $display("loopback word %0d = %02h", i, rx_words[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rx_en  = 1'b0;
    rst    = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tvalid[s] = 1'b0;
      tdata[s]  = 8'h00;
    end
    #2;
    test_reset();
    test_even();
    test_odd();
    test_none_two_stop();
    test_back_to_back(0, 8'hA5, 8'h3C);
    test_back_to_back(2, 8'h81, 8'h7E);
    test_reset_midframe();
    test_loopback();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks so far", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
